// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and helpers for Gray-code count handling
//
// Contents:
//   state_t   decoder FSM state encoding (IDLE, TRACK, RESYNC)
//   popcount  number of set bits in a 32-bit word
//   bin2gray  binary to Gray conversion, also used by benches
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  // Callers zero-extend narrower words; 6 bits hold counts up to 32.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational W-bit Gray to binary decoder
//
// Ports:
//   g  in   W  Gray-coded word
//   b  out  W  binary value, b[i] = XOR of g[W-1:i]
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    b = '0;
    for (int i = 0; i < W; i++) begin
      b[i] = ^(g >> i);
    end
  end

endmodule

// File: rtl/gray_count_decoder.sv
// rtl/gray_count_decoder.sv - Gray count sampler, legality checker and extended counter
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   gray_in   in   W   sampled Gray word
//   gray_vld  in   1   sample strobe
//   bin       out  W   binary value of last accepted sample
//   ext       out  EW  extended forward count
//   inc       out  1   pulse: legal +1 step accepted while tracking
//   err       out  1   pulse: illegal transition seen
//   locked    out  1   high while tracking
module gray_count_decoder #(
  parameter int W      = 4,
  parameter int EW     = 16,
  parameter int LOCK_N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  gray_in,
  input  logic          gray_vld,
  output logic [W-1:0]  bin,
  output logic [EW-1:0] ext,
  output logic          inc,
  output logic          err,
  output logic          locked
);

  import gray_pkg::*;

  localparam int CW = $clog2(LOCK_N + 1);

  state_t          state;
  logic [W-1:0]    prev_g;
  logic [W-1:0]    prev_b;
  logic [W-1:0]    b_dec;
  logic [W-1:0]    d;
  logic [5:0]      hd;
  logic            hold;
  logic            fwd;
  logic [CW-1:0]   good_cnt;
  logic [CW-1:0]   good_nxt;
  logic            carry;
  logic [EW-1:0]   relock_ext;

  gray_to_bin #(.W(W)) u_dec (
    .g (gray_in),
    .b (b_dec)
  );

  assign hd   = popcount(32'(gray_in ^ prev_g));
  assign d    = b_dec - prev_b;
  assign hold = (hd == 6'd0);
  assign fwd  = (hd == 6'd1) && (d == W'(1));

  assign good_nxt = good_cnt + CW'(1);

  // On re-lock the low bits jump to the current value; if that value is
  // numerically below the old low bits the counter must have wrapped while
  // we were resyncing, so carry once into the upper part. Written with
  // shifts so EW == W needs no empty slice.
  assign carry      = (b_dec < ext[W-1:0]);
  assign relock_ext = (((ext >> W) + EW'(carry)) << W) | EW'(b_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      prev_g   <= '0;
      prev_b   <= '0;
      bin      <= '0;
      ext      <= '0;
      good_cnt <= '0;
      inc      <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      inc <= 1'b0;
      err <= 1'b0;
      if (gray_vld) begin
        // History follows every sample, bad ones included, so the next
        // step is judged against what was actually seen last.
        prev_g <= gray_in;
        prev_b <= b_dec;
        bin    <= b_dec;
        case (state)
          ST_IDLE: begin
            ext    <= EW'(b_dec);
            state  <= ST_TRACK;
            locked <= 1'b1;
          end
          ST_TRACK: begin
            if (fwd) begin
              ext <= ext + EW'(1);
              inc <= 1'b1;
            end else if (!hold) begin
              err      <= 1'b1;
              good_cnt <= '0;
              state    <= ST_RESYNC;
              locked   <= 1'b0;
            end
          end
          ST_RESYNC: begin
            if (fwd) begin
              if (good_nxt == CW'(LOCK_N)) begin
                ext      <= relock_ext;
                good_cnt <= '0;
                state    <= ST_TRACK;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_nxt;
              end
            end else if (!hold) begin
              err      <= 1'b1;
              good_cnt <= '0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// tb/tb_gray_count_decoder.sv - self-checking bench for gray_count_decoder
module tb_gray_count_decoder;

  localparam int W      = 4;
  localparam int EW     = 8;
  localparam int LOCK_N = 2;

  logic          clk;
  logic          rst;
  logic [W-1:0]  gray_in;
  logic          gray_vld;
  logic [W-1:0]  bin;
  logic [EW-1:0] ext;
  logic          inc;
  logic          err;
  logic          locked;

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 = waiting for first sample, 1 = tracking, 2 = resyncing
  int m_state, m_good, m_ext, m_bin, m_prev_g, m_prev_b;
  int m_inc, m_err;

  gray_count_decoder #(.W(W), .EW(EW), .LOCK_N(LOCK_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .gray_vld (gray_vld),
    .bin      (bin),
    .ext      (ext),
    .inc      (inc),
    .err      (err),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int n);
    return (n ^ (n >> 1)) & 15;
  endfunction

  function automatic int index_of(input int g);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (gray_of(k) == g) n = k;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_good   = 0;
    m_ext    = 0;
    m_bin    = 0;
    m_prev_g = 0;
    m_prev_b = 0;
    m_inc    = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input int g, input bit vld);
    int n, hd, d;
    bit is_fwd;
    m_inc = 0;
    m_err = 0;
    if (vld) begin
      n      = index_of(g);
      hd     = $countones(32'(g ^ m_prev_g));
      d      = (n - m_prev_b + 16) % 16;
      is_fwd = (hd == 1) && (d == 1);
      if (m_state == 0) begin
        m_ext   = n;
        m_state = 1;
      end else if (m_state == 1) begin
        if (is_fwd) begin
          m_ext = (m_ext + 1) % 256;
          m_inc = 1;
        end else if (hd != 0) begin
          m_err   = 1;
          m_good  = 0;
          m_state = 2;
        end
      end else begin
        if (is_fwd) begin
          m_good++;
          if (m_good == LOCK_N) begin
            if (n < m_ext % 16) m_ext = ((m_ext / 16 + 1) * 16 + n) % 256;
            else                m_ext = (m_ext / 16) * 16 + n;
            m_good  = 0;
            m_state = 1;
          end
        end else if (hd != 0) begin
          m_err  = 1;
          m_good = 0;
        end
      end
      m_prev_g = g;
      m_prev_b = n;
      m_bin    = n;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_bin"},    32'(bin),    m_bin);
    chk({tag, "_ext"},    32'(ext),    m_ext);
    chk({tag, "_inc"},    32'(inc),    m_inc);
    chk({tag, "_err"},    32'(err),    m_err);
    chk({tag, "_locked"}, 32'(locked), (m_state == 1) ? 1 : 0);
  endtask

  task automatic drive(input string tag, input int g, input bit vld);
    gray_in  = 4'(g);
    gray_vld = vld;
    @(posedge clk);
    #1;
    model_step(g, vld);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    gray_vld = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int incs, errs, r, g;
    rst      = 1'b0;
    gray_vld = 1'b0;
    gray_in  = '0;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: first sample after reset locks with no pulse
    drive("t1", 0, 1'b1);
    chk("t1_locked_const", 32'(locked), 1);
    chk("t1_ext_const",    32'(ext),    0);

    // 2: full lap including wrap
    incs = 0;
    errs = 0;
    for (int n = 0; n < 16; n++) begin
      drive("t2", gray_of(n), 1'b1);
      incs += int'(inc);
      errs += int'(err);
    end
    drive("t2w", 0, 1'b1);
    incs += int'(inc);
    errs += int'(err);
    chk("t2_inc_count", incs, 16);
    chk("t2_err_count", errs, 0);
    chk("t2_ext_const", 32'(ext), 32'h10);
    chk("t2_bin_const", 32'(bin), 0);

    // 3: two-bit jump
    do_reset("t3r");
    for (int n = 0; n < 4; n++) drive("t3", gray_of(n), 1'b1);
    drive("t3e", gray_of(5), 1'b1);
    chk("t3_err_const",    32'(err),    1);
    chk("t3_locked_const", 32'(locked), 0);
    chk("t3_ext_const",    32'(ext),    3);
    chk("t3_bin_const",    32'(bin),    5);

    // 4: re-lock after LOCK_N forward steps, then backward step
    incs = 0;
    drive("t4a", gray_of(6), 1'b1);
    incs += int'(inc);
    drive("t4b", gray_of(7), 1'b1);
    incs += int'(inc);
    chk("t4_locked_const", 32'(locked), 1);
    chk("t4_ext_const",    32'(ext),    7);
    chk("t4_no_inc",       incs,        0);
    drive("t4bk", gray_of(5), 1'b1);
    chk("t4_back_err", 32'(err), 1);

    // 5: resync across a wrap carries into the upper bits
    do_reset("t5r");
    for (int n = 0; n < 15; n++) drive("t5", gray_of(n), 1'b1);
    drive("t5e", 0, 1'b1);
    chk("t5_err_const", 32'(err), 1);
    chk("t5_ext_hold",  32'(ext), 32'h0E);
    drive("t5a", gray_of(1), 1'b1);
    drive("t5b", gray_of(2), 1'b1);
    chk("t5_locked_const", 32'(locked), 1);
    chk("t5_ext_const",    32'(ext),    32'h12);

    // 6: repeated sample, idle strobe, then async reset mid-cycle
    drive("t6h", gray_of(2), 1'b1);
    chk("t6_hold_inc", 32'(inc), 0);
    for (int k = 0; k < 5; k++) drive("t6i", int'($urandom_range(0, 15)), 1'b0);
    chk("t6_ext_stable", 32'(ext), 32'h12);
    chk("t6_bin_stable", 32'(bin), 2);
    do_reset("t6r");
    chk("t6_rst_ext", 32'(ext), 0);

    // Randomized mix of forward, hold, arbitrary, idle and reset
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      g = gray_of((m_bin + 1) % 16);
      else if (r < 58) g = m_prev_g;
      else if (r < 66) g = gray_of((m_bin + 15) % 16);
      else if (r < 80) g = int'($urandom_range(0, 15));
      else             g = int'($urandom_range(0, 15));
      if (r >= 98)     do_reset("rndr");
      else             drive("rnd", g, (r < 80) ? 1'b1 : 1'b0);
      chk("rnd_excl", 32'(inc & err), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_count_decoder.md
# gray_count_decoder

Receive-side companion to `gray_counter`. Samples a Gray-coded count word and decodes it to binary. Checks every transition for legality: exactly one bit may change, and the count may only move forward. Extends the count to a wider binary total by counting wrap-arounds. Sits wherever a `gray_counter` value is consumed, for example a FIFO pointer reader or a position or event counter monitor.

## Interface
Parameters:
- `W`, 4, Gray/binary count width (≥2)
- `EW`, 16, extended count width (≥W)
- `LOCK_N`, 2, consecutive legal forward steps needed to re-lock after an error (≥1)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `gray_in`  in  W  sampled Gray code word
- `gray_vld`  in  1  sample strobe; `gray_in` is evaluated only when high
- `bin`  out  W  binary value of the last accepted sample
- `ext`  out  EW  extended forward count
- `inc`  out  1  one-cycle pulse: legal +1 step accepted in TRACK
- `err`  out  1  one-cycle pulse: illegal transition detected
- `locked`  out  1  high while in TRACK

## Operation
- Decode rule: `b[W-1]=g[W-1]`; `b[i]=b[i+1]^g[i]`.
- Registered history: `prev_g` (last sampled Gray word), `prev_b` (its binary value).
- Per valid sample:
  - hd = popcount(`gray_in ^ prev_g`).
  - d = (b − `prev_b`) mod 2^W.
- Classify each valid sample:
  - HOLD: hd==0.
  - FWD: hd==1 and d==1.
  - BAD: any other case. This covers hd≥2, and hd==1 with d==2^W−1 (a backward step).
- States and transitions:
  - IDLE (reset state): first valid sample loads `prev_g`, `bin`, and sets `ext`={0,b}. Go to TRACK. No pulse.
  - TRACK:
    - HOLD: no change.
    - FWD: `ext`+=1 (mod 2^EW), `inc` pulses.
    - BAD: `err` pulses, `ext` is held, `good_cnt`=0, go to RESYNC.
  - RESYNC:
    - FWD: `good_cnt`+=1.
    - HOLD: no change.
    - BAD: `err` pulses, `good_cnt`=0.
    - `ext` does not advance in RESYNC.
    - When `good_cnt` reaches LOCK_N, go to TRACK:
      - `ext[W-1:0]` := b.
      - `ext[EW-1:W]` += 1 if b < old `ext[W-1:0]`, otherwise held.
- `prev_g`, `prev_b` and `bin` update on every valid sample in every state, including BAD samples.
- Invariant in TRACK: `ext[W-1:0]==bin`.
- Wrap: step from 2^W−1 to 0 is FWD. The carry propagates into the upper bits of `ext`. `ext` itself wraps modulo 2^EW silently.

## Timing
- All outputs are registered. Latency from a valid sample edge to updated `bin`, `ext`, `inc`, `err` and `locked` is 1 cycle.
- `inc` and `err` are high for exactly one cycle per event. They are never high together. Both are low whenever `gray_vld` was low on the previous edge.
- `gray_vld` low: all state and outputs hold; pulses drop.
- Reset values: `bin`=0, `ext`=0, `inc`=0, `err`=0, `locked`=0, state IDLE, `good_cnt`=0, `prev_g`=0. These values apply immediately on `rst`, independent of `clk`.
- `rst` asserted mid-operation discards all history. After release, the first valid sample is treated as in IDLE.
- Back-to-back valid samples every cycle are supported; there is no throughput gap.

## Structure
- Shared package `gray_pkg`:
  - state encoding constants (IDLE, TRACK, RESYNC)
  - `popcount` function
  - `bin2gray` function, reused by benches
- Sub-module `gray_to_bin`: purely combinational W-bit decoder.
- `gray_count_decoder` holds the FSM, history registers, classifier and `ext`/`good_cnt` counters.

## Test plan
All scenarios use W=4, EW=8, LOCK_N=2, and count sequence g(n)=n^(n>>1).
1. Reset, then one valid sample 0000 → next cycle `bin`=0, `ext`=0x00, `locked`=1, `inc`=0, `err`=0.
2. Drive g(0)…g(15), g(0), one per cycle → 16 `inc` pulses, no `err`; final `bin`=0 and `ext`=0x10.
3. In TRACK at g(3)=0010, drive g(5)=0111 (hd=2) → `err` pulse, `locked`=0, `ext`=0x03, `bin`=5.
4. Continue with g(6)=0101, then g(7)=0100 → `locked`=1 after the second sample, `ext`=0x07, no `inc` pulses. Then drive g(5) after g(7) → `err`, because the step is backward.
5. Resync across a wrap: error at `ext`=0x0E, then drive g(1), g(2) → re-lock with `ext`=0x12.
6. Drive a repeated identical sample and hold `gray_vld` low for 5 cycles → no pulses, outputs stable. Assert `rst` between clock edges → all outputs are 0 before the next edge.
